perf_counter_bank: RTL and testbench

Synthesizable, parametrised event-counter bank for the pipelined processor. It counts retired instructions, I-cache and D-cache requests and hits, and cycles in hardware, and freezes all counts when the halt signal reaches write-back. It sits beside the processor core inside the top-level hierarchy. Counters are read through a registered select/readout port, so statistics are available on silicon and in gate-level simulation without hierarchical probes.

---
 rtl/perf_pkg.sv | 31 +++
 rtl/perf_ctr.sv | 57 +++++
 rtl/perf_counter_bank.sv | 141 ++++++++++++++
 tb/tb_perf_counter_bank.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// -----------------------------------------------------------------------------
// perf_pkg
//   Shared definitions for the performance-counter bank:
//     - perf_state_e : control FSM states (IDLE, RUN, FROZEN)
//     - EVT_*        : bit positions of the default event map on evt[]
//     - NUM_EVT_DEFAULT : number of event inputs in the default map
//     - evt_sel()    : readout select value for a given event index
// -----------------------------------------------------------------------------
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } perf_state_e;

    // Default event map on the evt[] strobes.
    localparam int EVT_INSTRET = 0;
    localparam int EVT_IREQ    = 1;
    localparam int EVT_IHIT    = 2;
    localparam int EVT_DREQ    = 3;
    localparam int EVT_DHIT    = 4;

    localparam int NUM_EVT_DEFAULT = 5;

    // Readout select 0 is the cycle counter, so event i sits at select i+1.
    function automatic int evt_sel(input int evt_idx);
        return evt_idx + 1;
    endfunction

endpackage

// File: rtl/perf_ctr.sv
// -----------------------------------------------------------------------------
// perf_ctr
//   One saturating up-counter with a sticky overflow flag.
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   asynchronous active-low reset (clears value and flag)
//     clr   in   synchronous clear, dominates inc
//     inc   in   add 1 on this edge
//     value out  current count (CNT_W bits), holds at all-ones
//     ovf   out  set by an increment attempted while value is all-ones;
//                stays set until clr or rst
// -----------------------------------------------------------------------------
module perf_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);

    logic [CNT_W-1:0] value_q, value_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        if (clr) begin
            value_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            // At full scale the count holds; the lost increment is recorded
            // in the sticky flag instead.
            if (&value_q) begin
                ovf_d = 1'b1;
            end else begin
                value_d = value_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value = value_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
//   Event-counter bank for the pipelined processor. Counts cycles and
//   NUM_EVT event strobes while in RUN, freezes when halt reaches write-back,
//   and exposes every counter through a registered select/readout port.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-low reset, clears the whole block
//     start      in   IDLE -> RUN
//     clr        in   synchronous clear of counters/flags, returns to IDLE
//     evt        in   per-cycle event strobes (NUM_EVT bits)
//     halt       in   halt instruction in write-back; RUN -> FROZEN
//     rd_sel     in   0 = cycle counter, i+1 = evt[i]; larger values read 0
//     rd_data    out  registered value of the selected counter
//     rd_ovf     out  registered sticky flag of the selected counter
//     running    out  state is RUN
//     done       out  state is FROZEN
//     ovf_any    out  OR of every counter's sticky flag
//     dbg_state  out  raw FSM state for observation
//
//   Control priority on a shared edge: rst, clr, halt, start. The halt cycle
//   itself is still a RUN cycle and is therefore counted.
// -----------------------------------------------------------------------------
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_EVT = NUM_EVT_DEFAULT,
    parameter int CNT_W   = 32,
    parameter int SEL_W   = $clog2(NUM_EVT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clr,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               halt,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_ovf,
    output logic               running,
    output logic               done,
    output logic               ovf_any,
    output perf_state_e        dbg_state
);

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    perf_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (clr) begin
            // clr outranks halt and start in every state.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;    // halt ignored here
                RUN:     if (halt)  state_d = FROZEN; // start ignored here
                FROZEN:  state_d = FROZEN;            // only clr leaves
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    logic run;
    assign run       = (state_q == RUN);
    assign running   = run;
    assign done      = (state_q == FROZEN);
    assign dbg_state = state_q;

    // -------------------------------------------------------------------------
    // Counter array: slot 0 counts cycles, slot i+1 counts evt[i].
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] ctr_val [NUM_EVT+1];
    logic [NUM_EVT:0] ctr_ovf;
    logic [NUM_EVT:0] ctr_inc;

    assign ctr_inc = {evt & {NUM_EVT{run}}, run};

    for (genvar g = 0; g <= NUM_EVT; g++) begin : g_ctr
        perf_ctr #(
            .CNT_W (CNT_W)
        ) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .inc   (ctr_inc[g]),
            .value (ctr_val[g]),
            .ovf   (ctr_ovf[g])
        );
    end

    assign ovf_any = |ctr_ovf;

    // -------------------------------------------------------------------------
    // Readout: the mux looks at the counters' current (pre-edge) values, so
    // the registered result never includes the increment of the same edge.
    // Selects beyond the last counter fall through to zero.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_ovf_q, rd_ovf_d;

    always_comb begin
        rd_data_d = '0;
        rd_ovf_d  = 1'b0;
        for (int i = 0; i <= NUM_EVT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data_d = ctr_val[i];
                rd_ovf_d  = ctr_ovf[i];
            end
        end
        if (clr) begin
            rd_data_d = '0;
            rd_ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
            rd_ovf_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_ovf_q  <= rd_ovf_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_ovf  = rd_ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
    import perf_pkg::*;

    localparam int NE  = 5;
    localparam int CW  = 32;
    localparam int SW  = 3;
    localparam int CWS = 4;

    // ---------------------------------------------------------------- clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT (32-bit)
    logic          rst, start, clr, halt;
    logic [NE-1:0] evt;
    logic [SW-1:0] rd_sel;
    logic [CW-1:0] rd_data;
    logic          rd_ovf, running, done, ovf_any;
    perf_state_e   dbg_state;

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(CW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clr       (clr),
        .evt       (evt),
        .halt      (halt),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rd_ovf    (rd_ovf),
        .running   (running),
        .done      (done),
        .ovf_any   (ovf_any),
        .dbg_state (dbg_state)
    );

    // ---------------------------------------------------------------- DUT (4-bit)
    logic           s_start, s_clr, s_halt;
    logic [NE-1:0]  s_evt;
    logic [SW-1:0]  s_rd_sel;
    logic [CWS-1:0] s_rd_data;
    logic           s_rd_ovf, s_running, s_done, s_ovf_any;
    perf_state_e    s_dbg_state;

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(CWS)) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .start     (s_start),
        .clr       (s_clr),
        .evt       (s_evt),
        .halt      (s_halt),
        .rd_sel    (s_rd_sel),
        .rd_data   (s_rd_data),
        .rd_ovf    (s_rd_ovf),
        .running   (s_running),
        .done      (s_done),
        .ovf_any   (s_ovf_any),
        .dbg_state (s_dbg_state)
    );

    // ---------------------------------------------------------------- scoreboard
    logic [63:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cnt [NE+1];

    task automatic sb_push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] exp_v;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
            end
        end
    endtask

    // Drive a select, then compare the registered readout one cycle later.
    task automatic read_main(input int sel, input logic [63:0] exp_d,
                             input logic exp_o, input string tag);
        @(negedge clk);
        rd_sel = SW'(sel);
        sb_push(exp_d);
        sb_push(64'(exp_o));
        @(negedge clk);
        check($sformatf("%s_sel%0d_data", tag, sel), 64'(rd_data));
        check($sformatf("%s_sel%0d_ovf", tag, sel), 64'(rd_ovf));
    endtask

    task automatic read_sat(input int sel, input logic [63:0] exp_d,
                            input logic exp_o, input string tag);
        @(negedge clk);
        s_rd_sel = SW'(sel);
        sb_push(exp_d);
        sb_push(64'(exp_o));
        @(negedge clk);
        check($sformatf("%s_sel%0d_data", tag, sel), 64'(s_rd_data));
        check($sformatf("%s_sel%0d_ovf", tag, sel), 64'(s_rd_ovf));
    endtask

    task automatic expect_val(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp_v);
        sb_push(exp_v);
        check(tag, obs);
    endtask

    task automatic check_all_main(input string tag);
        for (int s = 0; s <= NE; s++) begin
            read_main(s, 64'(cnt[s]), 1'b0, tag);
        end
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #500000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [NE-1:0] ev;
        int            s;

        rst = 1'b0; start = 1'b0; clr = 1'b0; halt = 1'b0;
        evt = '0; rd_sel = '0;
        s_start = 1'b0; s_clr = 1'b0; s_halt = 1'b0;
        s_evt = '0; s_rd_sel = '0;
        for (int i = 0; i <= NE; i++) cnt[i] = 0;

        // Reset values
        #2;
        expect_val("rst_rd_data", 64'(rd_data), 64'd0);
        expect_val("rst_rd_ovf", 64'(rd_ovf), 64'd0);
        expect_val("rst_running", 64'(running), 64'd0);
        expect_val("rst_done", 64'(done), 64'd0);
        expect_val("rst_ovf_any", 64'(ovf_any), 64'd0);
        expect_val("rst_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b1;

        // Events without start must not count
        evt = '1;
        repeat (10) @(negedge clk);
        evt = '0;
        expect_val("idle_running", 64'(running), 64'd0);
        expect_val("idle_done", 64'(done), 64'd0);
        check_all_main("idle");

        // Basic count: 20 RUN cycles, halt on the 20th
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        expect_val("basic_running", 64'(running), 64'd1);
        for (int k = 1; k <= 20; k++) begin
            ev    = NE'($urandom_range(0, 31));
            ev[EVT_IREQ] = (k <= 12);
            ev[EVT_IHIT] = (k <= 13) && (k % 2 == 1);
            evt   = ev;
            halt  = (k == 20);
            cnt[0]++;
            for (int i = 0; i < NE; i++) if (ev[i]) cnt[i+1]++;
            @(negedge clk);
        end
        evt = '0; halt = 1'b0;
        expect_val("basic_done", 64'(done), 64'd1);
        expect_val("basic_running_off", 64'(running), 64'd0);
        expect_val("basic_state", 64'(dbg_state), 64'(FROZEN));
        expect_val("basic_cyc20", 64'(cnt[0]), 64'd20);
        expect_val("basic_ireq12", 64'(cnt[evt_sel(EVT_IREQ)]), 64'd12);
        expect_val("basic_ihit7", 64'(cnt[evt_sel(EVT_IHIT)]), 64'd7);
        check_all_main("basic");

        // Frozen: events and a stray start change nothing
        for (int j = 0; j < 50; j++) begin
            evt   = NE'($urandom_range(0, 31));
            start = (j == 10);
            halt  = (j == 20);
            @(negedge clk);
        end
        evt = '0; start = 1'b0; halt = 1'b0;
        expect_val("frozen_done", 64'(done), 64'd1);
        check_all_main("frozen");

        // Readout sweep: new select every cycle, result one cycle later
        for (int j = 0; j < 14; j++) begin
            s = (j < 2) ? 6 + j : $urandom_range(0, 7);
            rd_sel = SW'(s);
            sb_push((s <= NE) ? 64'(cnt[s]) : 64'd0);
            @(negedge clk);
            check($sformatf("sweep%0d_sel%0d", j, s), 64'(rd_data));
        end

        // clr from FROZEN
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        expect_val("clr_state", 64'(dbg_state), 64'(IDLE));
        expect_val("clr_done", 64'(done), 64'd0);
        for (int i = 0; i <= NE; i++) cnt[i] = 0;
        check_all_main("clr");

        // Run 9 cycles, readout lags the count by one edge
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; evt = '1; rd_sel = '0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            expect_val($sformatf("lag%0d", j), 64'(rd_data), 64'(j - 1));
        end

        // clr and halt together: IDLE, all zero
        clr = 1'b1; halt = 1'b1;
        @(negedge clk); clr = 1'b0; halt = 1'b0; evt = '0;
        expect_val("clrhalt_state", 64'(dbg_state), 64'(IDLE));
        expect_val("clrhalt_running", 64'(running), 64'd0);
        expect_val("clrhalt_done", 64'(done), 64'd0);
        expect_val("clrhalt_ovf_any", 64'(ovf_any), 64'd0);
        check_all_main("clrhalt");

        // start and halt together in IDLE: RUN, halt not seen
        @(negedge clk); start = 1'b1; halt = 1'b1;
        @(negedge clk); start = 1'b0; halt = 1'b0;
        expect_val("starthalt_running", 64'(running), 64'd1);
        expect_val("starthalt_done", 64'(done), 64'd0);
        evt = '1; rd_sel = '0;
        repeat (9) @(negedge clk);
        expect_val("prerst_rd_data", 64'(rd_data), 64'd8);
        expect_val("prerst_running", 64'(running), 64'd1);

        // Asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        expect_val("arst_rd_data", 64'(rd_data), 64'd0);
        expect_val("arst_running", 64'(running), 64'd0);
        expect_val("arst_state", 64'(dbg_state), 64'(IDLE));
        expect_val("arst_ovf_any", 64'(ovf_any), 64'd0);
        evt = '0;
        @(negedge clk); rst = 1'b1;
        check_all_main("arst");

        // Saturation with 4-bit counters
        s_rd_sel = SW'(evt_sel(EVT_INSTRET));
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0; s_evt = '0; s_evt[EVT_INSTRET] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            s_halt = (k == 18);
            @(negedge clk);
            if (k == 15) expect_val("sat15_ovf_any", 64'(s_ovf_any), 64'd0);
            if (k == 16) expect_val("sat16_ovf_any", 64'(s_ovf_any), 64'd1);
        end
        s_halt = 1'b0; s_evt = '0;
        expect_val("sat_done", 64'(s_done), 64'd1);
        expect_val("sat_rd_data_lag", 64'(s_rd_data), 64'd15);
        read_sat(1, 64'd15, 1'b1, "sat");
        read_sat(0, 64'd15, 1'b1, "sat");
        read_sat(2, 64'd0, 1'b0, "sat");
        read_sat(6, 64'd0, 1'b0, "sat");
        expect_val("sat_ovf_any", 64'(s_ovf_any), 64'd1);

        // clr drops the sticky flags
        @(negedge clk); s_clr = 1'b1;
        @(negedge clk); s_clr = 1'b0;
        expect_val("satclr_ovf_any", 64'(s_ovf_any), 64'd0);
        expect_val("satclr_state", 64'(s_dbg_state), 64'(IDLE));
        read_sat(1, 64'd0, 1'b0, "satclr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
